// File: rtl/fp9_to_fixed_if.sv
// fp9_to_fixed handshake bundle: fp9 request side and fixed-point result side.
// W is the fixed-point result width and must match the converter's INT_W + FRAC_W.
interface fp9_to_fixed_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [8:0]   fp_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] fixed_out;
  logic         ovf;
  logic         zero;

  modport master (
    output in_valid, fp_in, out_ready,
    input  in_ready, out_valid, fixed_out, ovf, zero
  );

  modport slave (
    input  in_valid, fp_in, out_ready,
    output in_ready, out_valid, fixed_out, ovf, zero
  );
endinterface

// File: rtl/fp9_to_fixed.sv
// fp9 {sign, exp[3:0], fract[3:0]} to signed Q(INT_W).(FRAC_W), 1-bit/cycle shifter.
// Define FP9_TO_FIXED_ROUND_EN for round-to-nearest-even on right shifts.
module fp9_to_fixed #(
  parameter int BIAS   = 7,
  parameter int INT_W  = 10,
  parameter int FRAC_W = 6
) (
  input  logic          clk50M,
  input  logic          rst,
  fp9_to_fixed_if.slave bus
);
  localparam int W    = INT_W + FRAC_W;
  localparam int KOFF = FRAC_W - BIAS - 4;
  localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NEG_MAX = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, FIX, DONE} state_t;

  state_t            state;
  logic              sign;
  logic              left;
  logic              ovf_sticky;
  logic              zero_q;
  logic [W-1:0]      mag;
  logic [7:0]        cnt;
  logic [W-1:0]      fixed_r;
  logic              ovf_r;
  logic              zero_r;

  logic signed [7:0] k;
  logic [7:0]        k_abs;
  logic              is_zero;
  logic [W-1:0]      mag_fix;
  logic              pos_ovf;
  logic              neg_ovf;

  assign k       = 8'(int'(bus.fp_in[7:4]) + KOFF);
  assign k_abs   = k[7] ? 8'(-k) : k;
  assign is_zero = (bus.fp_in[7:0] == 8'h00);

`ifdef FP9_TO_FIXED_ROUND_EN
  logic guard;
  logic sticky;
  assign mag_fix = mag + W'(guard & (sticky | mag[0]));
`else
  assign mag_fix = mag;
`endif

  assign pos_ovf = ovf_sticky | mag_fix[W-1];
  assign neg_ovf = ovf_sticky | (mag_fix > NEG_MAX);

  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sign       <= 1'b0;
      left       <= 1'b0;
      ovf_sticky <= 1'b0;
      zero_q     <= 1'b0;
      mag        <= '0;
      cnt        <= '0;
      fixed_r    <= '0;
      ovf_r      <= 1'b0;
      zero_r     <= 1'b0;
`ifdef FP9_TO_FIXED_ROUND_EN
      guard      <= 1'b0;
      sticky     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign       <= bus.fp_in[8];
            left       <= !k[7] && (k != 8'sd0);
            ovf_sticky <= 1'b0;
            zero_q     <= is_zero;
`ifdef FP9_TO_FIXED_ROUND_EN
            guard      <= 1'b0;
            sticky     <= 1'b0;
`endif
            if (is_zero) begin
              mag   <= '0;
              cnt   <= '0;
              state <= FIX;
            end else begin
              mag   <= W'({1'b1, bus.fp_in[3:0]});
              cnt   <= k_abs;
              state <= (k_abs != 8'd0) ? SHIFT : FIX;
            end
          end
        end
        SHIFT: begin
          if (left) begin
            ovf_sticky <= ovf_sticky | mag[W-1];
            mag        <= mag << 1;
          end else begin
            mag    <= mag >> 1;
`ifdef FP9_TO_FIXED_ROUND_EN
            guard  <= mag[0];
            sticky <= sticky | guard;
`endif
          end
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) state <= FIX;
        end
        FIX: begin
          zero_r <= zero_q;
          if (!sign) begin
            fixed_r <= pos_ovf ? POS_MAX : mag_fix;
            ovf_r   <= pos_ovf;
          end else begin
            fixed_r <= neg_ovf ? NEG_MAX : W'(~mag_fix + 1'b1);
            ovf_r   <= neg_ovf;
          end
          state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.fixed_out = fixed_r;
  assign bus.ovf       = ovf_r;
  assign bus.zero      = zero_r;
endmodule

// File: tb/tb_fp9_to_fixed.sv
// Directed bench for fp9_to_fixed: default build (W=16) and INT_W=6 (W=12).
// Expected values are hand-computed from the fp9 encoding.
module tb_fp9_to_fixed;
  logic clk50M = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk50M = ~clk50M;

  fp9_to_fixed_if #(.W(16)) a ();
  fp9_to_fixed_if #(.W(12)) b ();

  fp9_to_fixed u_a (
    .clk50M(clk50M),
    .rst   (rst),
    .bus   (a.slave)
  );

  fp9_to_fixed #(.INT_W(6)) u_b (
    .clk50M(clk50M),
    .rst   (rst),
    .bus   (b.slave)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input bit s, output int n);
    bit seen;
    n    = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk50M);
      n++;
      #1;
      if (s) b.in_valid = 1'b0;
      else   a.in_valid = 1'b0;
      if ((s ? b.out_valid : a.out_valid) === 1'b1) seen = 1;
    end
  endtask

  task automatic conv(input bit s, input logic [8:0] fp,
                      input int lat, input logic [15:0] fx,
                      input logic o, input logic z,
                      input string t);
    int n;
    if (s) begin
      b.fp_in = fp; b.in_valid = 1'b1; b.out_ready = 1'b0;
    end else begin
      a.fp_in = fp; a.in_valid = 1'b1; a.out_ready = 1'b0;
    end
    wait_valid(s, n);
    check({t, "_lat"}, n, lat);
    if (s) begin
      check({t, "_fix"}, 32'(b.fixed_out), 32'(fx));
      check({t, "_ovf"}, 32'(b.ovf), 32'(o));
      check({t, "_zero"}, 32'(b.zero), 32'(z));
      b.out_ready = 1'b1;
    end else begin
      check({t, "_fix"}, 32'(a.fixed_out), 32'(fx));
      check({t, "_ovf"}, 32'(a.ovf), 32'(o));
      check({t, "_zero"}, 32'(a.zero), 32'(z));
      a.out_ready = 1'b1;
    end
    @(posedge clk50M);
    #1;
    a.out_ready = 1'b0;
    b.out_ready = 1'b0;
    check({t, "_idle"}, 32'(s ? b.in_ready : a.in_ready), 32'd1);
  endtask

  initial begin
    int n;
    logic [15:0] rnd3;
    logic [15:0] rnd_drain;
`ifdef FP9_TO_FIXED_ROUND_EN
    rnd3      = 16'h0004;
    rnd_drain = 16'h0001;
`else
    rnd3      = 16'h0003;
    rnd_drain = 16'h0000;
`endif
    rst = 1'b0;
    a.in_valid = 1'b0; a.fp_in = '0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.fp_in = '0; b.out_ready = 1'b0;
    repeat (3) @(posedge clk50M);
    #1;
    check("rst_in_ready", 32'(a.in_ready), 32'd1);
    check("rst_out_valid", 32'(a.out_valid), 32'd0);
    check("rst_fixed", 32'(a.fixed_out), 32'd0);
    check("rst_ovf", 32'(a.ovf), 32'd0);
    check("rst_zero", 32'(a.zero), 32'd0);
    rst = 1'b1;
    @(posedge clk50M);
    #1;

    conv(0, 9'h070, 4,  16'h0040, 0, 0, "one");
    conv(0, 9'h188, 5,  16'hFF40, 0, 0, "neg3");
    conv(0, 9'h000, 2,  16'h0000, 0, 1, "zero");
    conv(0, 9'h100, 2,  16'h0000, 0, 1, "negzero");
    conv(0, 9'h058, 2,  16'h0018, 0, 0, "k0");
    conv(0, 9'h02E, 5,  rnd3,     0, 0, "round");
    conv(0, 9'h001, 7,  rnd_drain, 0, 0, "drain");
    conv(0, 9'h0F0, 12, 16'h4000, 0, 0, "exp15");
    conv(0, 9'h1FF, 12, 16'h8400, 0, 0, "negmax16");

    conv(1, 9'h0FF, 12, 16'h07FF, 1, 0, "w12_possat");
    conv(1, 9'h1FF, 12, 16'h0800, 1, 0, "w12_negsat");
    conv(1, 9'h1C0, 9,  16'h0800, 0, 0, "w12_negexact");
    conv(1, 9'h0C0, 9,  16'h07FF, 1, 0, "w12_posedge");
    conv(1, 9'h070, 4,  16'h0040, 0, 0, "w12_one");

    // back-to-back: second request waits for the out_ready handshake
    a.fp_in = 9'h070; a.in_valid = 1'b1; a.out_ready = 1'b0;
    wait_valid(0, n);
    a.in_valid = 1'b1;
    a.fp_in = 9'h188;
    check("b2b_lat", n, 4);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk50M);
      #1;
      check("b2b_in_ready", 32'(a.in_ready), 32'd0);
      check("b2b_out_valid", 32'(a.out_valid), 32'd1);
      check("b2b_hold", 32'(a.fixed_out), 32'h0040);
    end
    a.out_ready = 1'b1;
    @(posedge clk50M);
    #1;
    a.out_ready = 1'b0;
    check("b2b_reopen", 32'(a.in_ready), 32'd1);
    wait_valid(0, n);
    check("b2b2_lat", n, 5);
    check("b2b2_fix", 32'(a.fixed_out), 32'hFF40);
    a.out_ready = 1'b1;
    @(posedge clk50M);
    #1;
    a.out_ready = 1'b0;

    // asynchronous reset in the middle of SHIFT
    a.fp_in = 9'h0F0; a.in_valid = 1'b1;
    @(posedge clk50M);
    #1;
    a.in_valid = 1'b0;
    repeat (2) @(posedge clk50M);
    #1;
    check("mid_busy", 32'(a.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", 32'(a.in_ready), 32'd1);
    check("mid_rst_valid", 32'(a.out_valid), 32'd0);
    check("mid_rst_fixed", 32'(a.fixed_out), 32'd0);
    check("mid_rst_ovf", 32'(a.ovf), 32'd0);
    check("mid_rst_zero", 32'(a.zero), 32'd0);
    #1;
    rst = 1'b1;
    @(posedge clk50M);
    #1;
    conv(0, 9'h070, 4, 16'h0040, 0, 0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fp9_to_fixed.md
Name: fp9_to_fixed

Overview:
- Converts the 9-bit float format {sign[8], exp[7:4], fract[3:0]} back to signed two's-complement fixed point. The value is (-1)^s × 1.fract × 2^(exp−BIAS).
- It is the inverse of the add/normalize path. That path packs wide sums into fp9; this block unpacks fp9 results for integer consumers such as the ALU writeback and display.
- It denormalizes iteratively with a 1-bit/cycle shifter and uses valid/ready handshakes on both sides.

Parameters:
- BIAS, 7, exponent bias.
- INT_W, 10, integer bits of the output, including the sign bit.
- FRAC_W, 6, fractional bits of the output.
- W = INT_W + FRAC_W is a localparam, default 16.

Ports:
- clk50M  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  fp_in is valid.
- in_ready  out  1  block can accept; high only in IDLE.
- fp_in  in  9  {sign, exp[3:0], fract[3:0]}.
- out_valid  out  1  fixed_out, ovf and zero are valid.
- out_ready  in  1  consumer accepts the result.
- fixed_out  out  W  signed Q(INT_W).(FRAC_W) result.
- ovf  out  1  result saturated.
- zero  out  1  input was the zero encoding.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, fixed_out=0, ovf=0, zero=0, out_valid=0, and all internal registers cleared. Reset mid-operation aborts the conversion and discards it.
- States: IDLE, SHIFT, FIX, DONE. in_ready=(state==IDLE). out_valid=(state==DONE).
- IDLE, on in_valid:
  - Capture the sign.
  - mag[W-1:0] = {1, fract}, zero-extended; this is 5 significant bits.
  - k = exp − BIAS − 4 + FRAC_W, computed signed, 6 bits minimum. With defaults k = exp−5, range −5..10.
  - cnt = |k|, dir = left if k>0, else right.
  - Zero encoding (exp=0 and fract=0): mag=0, cnt=0, zero flag set.
  - Next state is SHIFT if cnt≠0, else FIX.
- SHIFT, once per cycle:
  - Left shift: ovf_sticky |= mag[W-1], then mag <<= 1.
  - Right shift: mag >>= 1, truncating.
  - cnt−−. When cnt reaches 0 on this edge, go to FIX.
- FIX, one cycle:
  - pos_ovf = ovf_sticky | mag[W-1].
  - Sign=0: if pos_ovf, fixed_out = 2^(W-1)−1 and ovf=1; else fixed_out = mag.
  - Sign=1: if ovf_sticky, or mag > 2^(W-1), fixed_out = −2^(W-1) and ovf=1. Otherwise fixed_out = −mag; exactly 2^(W-1) is representable, so ovf=0.
  - Go to DONE.
- DONE: outputs are held stable while out_ready=0. On out_ready=1, go to IDLE. fixed_out, ovf and zero keep their values until the next FIX.
- Latency: an accept at edge e0 gives out_valid high after edge e0+|k|+2. Defaults give 2..12 cycles.
- Throughput: one conversion in flight. No input is accepted in SHIFT, FIX or DONE, even when out_ready and in_valid are both high in DONE.
- in_valid while in_ready=0 is ignored; no data is captured.
- Right shifts beyond W bits drain mag to 0. The result is 0 with ovf=0 and zero=0.
- The format has no inf or NaN; exp=15 is an ordinary exponent.

Optional Feature:
- Macro: FP9_TO_FIXED_ROUND_EN.
- Defined:
  - During right shifts, guard = the last bit shifted out, and sticky = OR of all earlier shifted-out bits.
  - In FIX, round to nearest even before the sign and saturation logic: mag += guard & (sticky | mag[0]).
  - If the increment makes mag[W-1] set, the FIX overflow rules apply to it.
  - Latency is unchanged.
- Undefined: right shifts truncate, and no guard or sticky logic is built.

Test Plan:
- Default parameters:
  - fp_in=0_0111_0000 (1.0) -> fixed_out=0x0040, ovf=0, zero=0; out_valid 4 cycles after accept.
  - fp_in=1_1000_1000 (−3.0) -> fixed_out=0xFF40, ovf=0; latency 5.
  - fp_in=0_0000_0000 -> fixed_out=0x0000, zero=1; latency 2.
  - Back-to-back: in_valid held high, out_ready low for 6 cycles in DONE -> in_ready=0 and outputs stable throughout. Next input accepted only after the out_ready handshake.
- INT_W=6 (W=12):
  - fp_in=0_1111_1111 -> fixed_out=0x7FF, ovf=1.
  - fp_in=1_1111_1111 -> fixed_out=0x800, ovf=1.
- Rounding, default parameters: fp_in=0_0010_1110 (k=−3, mag 30 -> 3.75 LSB) -> fixed_out=0x0003 without the macro, 0x0004 with FP9_TO_FIXED_ROUND_EN.
- Reset mid-operation: rst pulsed low during SHIFT of 0_1111_0000 -> all outputs 0 and state IDLE immediately. A following 0_0111_0000 converts to 0x0040.
